upack_sample_router: RTL
========================

UPACK_SAMPLE_ROUTER -- requirements
Module: upack_sample_router

Interface
REQ-001 Parameter SAMPLE_W, default 16, is the width of one sample in bits; the channel count SHALL be fixed at 4.
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 enable  input  4  is the channel enable mask, where bit k enables channel k.
REQ-005 s_axis_valid  input  1  indicates that an upstream packed word is present.
REQ-006 s_axis_ready  output  1  indicates that the block can accept a packed word.
REQ-007 s_axis_data  input  4*SAMPLE_W  carries 4 packed samples, with sample 0 in the LSBs.
REQ-008 m_axis_valid  output  1  indicates that an output beat is available.
REQ-009 m_axis_ready  input  1  indicates that the downstream block accepts the output beat.
REQ-010 m_data_0 .. m_data_3  output  SAMPLE_W each  carry the per-channel output samples.
REQ-011 underflow_count  output  16  is the saturating starvation counter defined in the Configuration section.

Function
REQ-012 N SHALL equal popcount(enable).
REQ-013 An input transfer SHALL occur when s_axis_valid and s_axis_ready are both 1; an output transfer SHALL occur when m_axis_valid and m_axis_ready are both 1.
REQ-014 The block SHALL hold an 8-slot sample buffer and a count register of range 0..8; slot 0 is the oldest sample.
REQ-015 s_axis_ready SHALL be registered-state-only: it is 1 iff count <= 4, and it has no combinational path from m_axis_ready.
REQ-016 m_axis_valid SHALL be 1 iff N != 0 and count >= N.
REQ-017 For an enabled channel k, m_data_k SHALL equal buffer slot r, where r is the number of enabled channels with index below k.
REQ-018 m_data_k of a disabled channel SHALL be 0.
REQ-019 On an output transfer, the buffer SHALL shift down by N slots and count SHALL decrease by N.
REQ-020 On an input transfer, the 4 samples SHALL be written to slots p..p+3, where p is the count after any same-cycle pop is applied.
REQ-021 Simultaneous push and pop: count_next SHALL equal count - N + 4.
REQ-022 Latency: a word accepted at edge t SHALL be able to produce m_axis_valid=1 in the cycle following edge t (one-cycle latency).
REQ-023 Outputs SHALL be driven directly from registers; there SHALL be no further pipelining.
REQ-024 When N == 0, every valid input word SHALL be accepted and discarded: count stays 0, m_axis_valid stays 0, and s_axis_ready stays 1.
REQ-025 A change of enable, detected against a registered copy of enable, SHALL clear count on the next edge and discard any partial data; the input word on that edge SHALL be dropped.
REQ-026 Data order SHALL be preserved across buffer wrap-around; for example, with N=3 samples carry over between beats without loss or reordering.

Reset
REQ-027 While reset is 1, count SHALL be 0, buffer slots SHALL be 0, and the registered enable SHALL be 0.
REQ-028 While reset is 1, underflow_count SHALL be 0.
REQ-029 While reset is 1, m_axis_valid SHALL be 0, s_axis_ready SHALL be 1, and m_data_0..3 SHALL be 0.
REQ-030 A reset asserted mid-operation SHALL discard all buffered samples immediately; the first word accepted after release SHALL map to slot 0.

Configuration
REQ-031 With UPACK_UNDERFLOW_CNT_EN defined, underflow_count SHALL increment, saturating at 0xFFFF, in each cycle where N != 0, m_axis_ready is 1 and m_axis_valid is 0.
REQ-032 Without UPACK_UNDERFLOW_CNT_EN, underflow_count SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-033 enable=1111, push word with samples 1,2,3,4, m_axis_ready=1 -> one beat next cycle with m_data_0..3 = 1,2,3,4; count returns to 0.
REQ-034 enable=0101, push samples 1,2,3,4 -> first beat m_data_0=1, m_data_2=2; second beat m_data_0=3, m_data_2=4; m_data_1 and m_data_3 are 0 throughout.
REQ-035 enable=0111, push samples 1..4 then 5..8 -> beats (1,2,3) and (4,5,6); count ends at 2; a third push of 9..12 yields beats (7,8,9) and (10,11,12).
REQ-036 enable=0001, m_axis_ready=0, continuous valid input -> s_axis_ready drops to 0 after the 2nd accepted word (count=8); no data is lost; after m_axis_ready=1 the outputs are 1..8 in order.
REQ-037 Assert reset with count=5, then push samples 1..4 with enable=1111 -> the first beat after release is 1,2,3,4; also, toggling enable from 1111 to 0011 mid-stream clears count within one cycle.
REQ-038 enable=0011, m_axis_ready=1, no input for 10 cycles -> underflow_count=10 with UPACK_UNDERFLOW_CNT_EN defined, and 0 without it.

Source files
------------

// File: rtl/upack_sample_router_if.sv
// Stream bundle for upack_sample_router: packed input word channel plus the
// per-channel output beat channel. The router itself uses the slave modport.
interface upack_sample_router_if #(
  parameter int SAMPLE_W = 16
);
  logic                  s_axis_valid;
  logic                  s_axis_ready;
  logic [4*SAMPLE_W-1:0] s_axis_data;
  logic                  m_axis_valid;
  logic                  m_axis_ready;
  logic [SAMPLE_W-1:0]   m_data_0;
  logic [SAMPLE_W-1:0]   m_data_1;
  logic [SAMPLE_W-1:0]   m_data_2;
  logic [SAMPLE_W-1:0]   m_data_3;

  modport master (
    output s_axis_valid, s_axis_data, m_axis_ready,
    input  s_axis_ready, m_axis_valid, m_data_0, m_data_1, m_data_2, m_data_3
  );

  modport slave (
    input  s_axis_valid, s_axis_data, m_axis_ready,
    output s_axis_ready, m_axis_valid, m_data_0, m_data_1, m_data_2, m_data_3
  );
endinterface

// File: rtl/upack_sample_router.sv
// upack_sample_router: unpacks 4-sample words into beats carrying one sample
// per enabled channel. An 8-slot shift buffer holds samples, oldest in slot 0.
// Optional feature: define UPACK_UNDERFLOW_CNT_EN to build the saturating
// starvation counter; otherwise underflow_count is tied to 0.
module upack_sample_router #(
  parameter int SAMPLE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            enable,
  upack_sample_router_if.slave  bus,
  output logic [15:0]           underflow_count
);

  logic [SAMPLE_W-1:0] r_buf [8];
  logic [3:0]          r_count;
  logic [3:0]          r_enable;

  logic [SAMPLE_W-1:0] w_buf_nxt [8];
  logic [SAMPLE_W-1:0] w_in [4];
  logic [3:0]          w_n;
  logic [3:0]          w_pop_n;
  logic [3:0]          w_base;
  logic [3:0]          w_count_nxt;
  logic                w_pop;
  logic                w_push;
  logic                w_en_chg;
  logic [2:0]          w_rank1;
  logic [2:0]          w_rank2;
  logic [2:0]          w_rank3;

  // N comes from the registered mask so the output side never sees the raw input
  assign w_n = {3'b000, r_enable[0]} + {3'b000, r_enable[1]} +
               {3'b000, r_enable[2]} + {3'b000, r_enable[3]};

  assign bus.s_axis_ready = (r_count <= 4'd4);
  assign bus.m_axis_valid = (w_n != 4'd0) && (r_count >= w_n);

  assign w_en_chg    = (enable != r_enable);
  assign w_pop       = bus.m_axis_valid && bus.m_axis_ready;
  // with no channel enabled the word is accepted but never stored
  assign w_push      = bus.s_axis_valid && bus.s_axis_ready && (w_n != 4'd0);
  assign w_pop_n     = w_pop ? w_n : 4'd0;
  assign w_base      = r_count - w_pop_n;
  assign w_count_nxt = w_base + (w_push ? 4'd4 : 4'd0);

  // split the packed input word into samples, sample 0 in the LSBs
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_in[j] = bus.s_axis_data[j*SAMPLE_W +: SAMPLE_W];
    end
  end

  // shift out the popped samples, then append the new word behind what remains
  always_comb begin
    logic [3:0] v_idx;
    logic [3:0] v_src;
    logic [1:0] v_off;
    for (int i = 0; i < 8; i++) begin
      v_idx = 4'(i);
      v_src = v_idx + w_pop_n;
      v_off = v_idx[1:0] - w_base[1:0];
      w_buf_nxt[i] = (v_src < 4'd8) ? r_buf[v_src[2:0]] : '0;
      if (w_push && (v_idx >= w_base) && (v_idx < w_base + 4'd4)) begin
        w_buf_nxt[i] = w_in[v_off];
      end
    end
  end

  // buffer, fill level and mask copy; a mask change flushes and drops that edge's word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_enable <= '0;
      for (int i = 0; i < 8; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_en_chg) begin
      r_count  <= '0;
      r_enable <= enable;
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < 8; i++) begin
        r_buf[i] <= w_buf_nxt[i];
      end
    end
  end

  // each enabled channel reads the slot equal to the number of enabled channels below it
  assign w_rank1 = {2'b00, r_enable[0]};
  assign w_rank2 = w_rank1 + {2'b00, r_enable[1]};
  assign w_rank3 = w_rank2 + {2'b00, r_enable[2]};

  assign bus.m_data_0 = r_enable[0] ? r_buf[0]       : '0;
  assign bus.m_data_1 = r_enable[1] ? r_buf[w_rank1] : '0;
  assign bus.m_data_2 = r_enable[2] ? r_buf[w_rank2] : '0;
  assign bus.m_data_3 = r_enable[3] ? r_buf[w_rank3] : '0;

`ifdef UPACK_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow;

  // count cycles where downstream is ready but no full beat is buffered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underflow <= '0;
    end else if ((w_n != 4'd0) && bus.m_axis_ready && !bus.m_axis_valid &&
                 (r_underflow != 16'hFFFF)) begin
      r_underflow <= r_underflow + 16'd1;
    end
  end

  assign underflow_count = r_underflow;
`else
  assign underflow_count = 16'd0;
`endif

endmodule
